// File: rtl/bitscan_encoder_pkg.sv
// Shared types and helpers for the bitscan encoder: FSM state enum and lowest-set-bit search.
// Latency: none, purely declarative / combinational helpers.
// Backpressure: not applicable.
package encoder_pkg;

  // Widest vector the helper function is written for; narrower callers zero-extend.
  localparam int unsigned MAX_W     = 64;
  localparam int unsigned MAX_IDX_W = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  typedef struct packed {
    logic [MAX_IDX_W-1:0] idx;
    logic                 found;
  } lsb_t;

  // Scan from the top down so the last hit written is the lowest set bit.
  function automatic lsb_t lsb_index(input logic [MAX_W-1:0] vec);
    lsb_t r;
    r.idx   = '0;
    r.found = 1'b0;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.idx   = MAX_IDX_W'(i);
        r.found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bitscan_encoder_if.sv
// Vector-in / index-out handshake bundle for the bitscan encoder.
// Latency: none, wires only.
// Backpressure: carries vec valid/ready and idx valid/ready pairs.
interface bitscan_encoder_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] vec_i;
  logic             vec_valid_i;
  logic             vec_ready_o;
  logic [IDX_W-1:0] idx_o;
  logic             idx_valid_o;
  logic             idx_ready_i;
  logic             last_o;

  // Producer of vectors and consumer of indices.
  modport master (
    output vec_i, vec_valid_i, idx_ready_i,
    input  vec_ready_o, idx_o, idx_valid_o, last_o
  );

  // The encoder itself.
  modport slave (
    input  vec_i, vec_valid_i, idx_ready_i,
    output vec_ready_o, idx_o, idx_valid_o, last_o
  );

endinterface

// File: rtl/lsb_priority_encoder.sv
// Combinational lowest-set-bit priority encoder: returns index of bit 0-most set bit plus found flag.
// Latency: zero cycles, purely combinational.
// Backpressure: none.
module lsb_priority_encoder
  import encoder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]         in,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     found
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  lsb_t res;

  // Zero-extend to the helper's full width; upper bits never win since they are zero.
  always_comb begin
    res = lsb_index(MAX_W'(in));
  end

  assign idx   = IDX_W'(res.idx);
  assign found = res.found;

endmodule

// File: rtl/bitscan_encoder.sv
// Accepts a multi-hot vector and emits the index of each set bit, lowest first, one beat per cycle.
// Latency: first beat one cycle after accept; one IDLE cycle after the last beat before the next accept.
// Backpressure: idx_ready_i low holds idx_o/last_o; vec_ready_o is low for the whole drain. Optional zero_o via BITSCAN_ZERO_FLAG_EN.
module bitscan_encoder
  import encoder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  bitscan_encoder_if.slave  bus
`ifdef BITSCAN_ZERO_FLAG_EN
  ,
  output logic              zero_o
`endif
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  // Reject illegal widths at elaboration rather than producing a silently broken encoder.
  if (WIDTH < 2 || WIDTH > MAX_W) begin : g_width_check
    $error("bitscan_encoder: WIDTH must be in 2..64");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;
`ifdef BITSCAN_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif

  logic [IDX_W-1:0] vec_idx;
  logic             vec_found;
  logic [IDX_W-1:0] pend_idx;
  logic             pend_found;

  // Lowest set bit of the incoming vector, used on accept.
  lsb_priority_encoder #(.WIDTH(WIDTH)) u_enc_vec (
    .in    (bus.vec_i),
    .idx   (vec_idx),
    .found (vec_found)
  );

  // Lowest set bit still waiting to be emitted.
  lsb_priority_encoder #(.WIDTH(WIDTH)) u_enc_pend (
    .in    (pending_q),
    .idx   (pend_idx),
    .found (pend_found)
  );

  // Next-state and datapath: load on accept, advance to the next set bit on each taken beat.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    last_d    = last_q;
`ifdef BITSCAN_ZERO_FLAG_EN
    zero_d    = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.vec_valid_i) begin
          if (vec_found) begin
            state_d   = DRAIN;
            idx_d     = vec_idx;
            // x & (x-1) clears exactly the lowest set bit.
            pending_d = bus.vec_i & (bus.vec_i - WIDTH'(1));
            last_d    = (pending_d == '0);
`ifdef BITSCAN_ZERO_FLAG_EN
            zero_d    = 1'b0;
          end else begin
            // A zero vector still yields one flagged beat so the consumer sees it.
            state_d   = DRAIN;
            idx_d     = '0;
            pending_d = '0;
            last_d    = 1'b1;
            zero_d    = 1'b1;
`endif
          end
        end
      end
      DRAIN: begin
        if (bus.idx_ready_i) begin
          if (pend_found) begin
            idx_d     = pend_idx;
            pending_d = pending_q & (pending_q - WIDTH'(1));
            last_d    = (pending_d == '0);
`ifdef BITSCAN_ZERO_FLAG_EN
            zero_d    = 1'b0;
`endif
          end else begin
            state_d = IDLE;
            last_d  = 1'b0;
`ifdef BITSCAN_ZERO_FLAG_EN
            zero_d  = 1'b0;
`endif
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pending bits and output registers; reset discards any in-flight vector.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
`ifdef BITSCAN_ZERO_FLAG_EN
      zero_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
`ifdef BITSCAN_ZERO_FLAG_EN
      zero_q    <= zero_d;
`endif
    end
  end

  // Handshake flags come straight from the state so reset clears them without a clock.
  assign bus.vec_ready_o = (state_q == IDLE);
  assign bus.idx_valid_o = (state_q == DRAIN);
  assign bus.idx_o       = idx_q;
  assign bus.last_o      = last_q;
`ifdef BITSCAN_ZERO_FLAG_EN
  assign zero_o          = zero_q;
`endif

endmodule

// File: doc/bitscan_encoder.md
Name: bitscan_encoder

Overview:
Sequential encoder that reverses the job of the enabled decoder: it accepts a multi-hot vector, then emits the binary index of each set bit, lowest first, one beat per cycle. It uses a valid/ready handshake on both sides. It sits between request/enable vectors (register-write enables, interrupt or flag lines) and logic that consumes one encoded index at a time.

Parameters:
WIDTH, 8, input vector width; legal range 2..64.
IDX_W, $clog2(WIDTH), index width; derived localparam, not overridable.

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_ni  input  1  asynchronous active-low reset
vec_i  input  WIDTH  multi-hot vector to encode
vec_valid_i  input  1  vec_i valid
vec_ready_o  output  1  block can accept a vector
idx_o  output  IDX_W  encoded index of current set bit
idx_valid_o  output  1  idx_o valid
idx_ready_i  input  1  consumer accepts idx_o
last_o  output  1  current beat is the final set bit of the vector

Behaviour:
- Reset (rst_ni low, asynchronous): state=IDLE, pending=0, idx_o=0, idx_valid_o=0, last_o=0, vec_ready_o=1. The first transfer is the first rising edge after rst_ni rises.
- States:
  - IDLE: vec_ready_o=1, idx_valid_o=0.
  - DRAIN: vec_ready_o=0, idx_valid_o=1.
- Accept: on an edge with vec_valid_i & vec_ready_o and vec_i != 0:
  - idx_o <= lowest set index of vec_i
  - pending <= vec_i with that bit cleared
  - last_o <= (cleared vector == 0)
  - go to DRAIN
  - Latency: first beat is visible the cycle after accept.
- Output handshake: a beat transfers on an edge with idx_valid_o & idx_ready_i.
  - If pending != 0: load next lowest index, clear it from pending, update last_o. Beats are back-to-back, one per cycle.
  - If pending == 0 (last beat): go to IDLE, idx_valid_o <= 0, last_o <= 0.
- Stall: while idx_valid_o=1 and idx_ready_i=0, idx_o and last_o hold stable.
- Throughput: popcount(vec_i) beats, plus one IDLE cycle before the next vector can be accepted. No overlap of vectors.
- Zero vector: behaviour is set by the optional feature below.
- vec_i is sampled only at accept. Changes to vec_i during DRAIN are ignored.
- Reset mid-DRAIN: the remaining pending bits are discarded and no further beats are emitted.
- Priority: the lowest index always goes first. Index arithmetic is unsigned, IDX_W bits wide.

Optional Feature:
Macro BITSCAN_ZERO_FLAG_EN.
- Defined: adds port zero_o (output, 1 bit, reset 0). An accepted zero vector produces exactly one beat with idx_o=0, last_o=1 and zero_o=1. zero_o is 0 on all other beats.
- Not defined: no zero_o port. An accepted zero vector is consumed silently: no beat, the block stays in IDLE and vec_ready_o remains 1.

Decomposition:
- Shared package encoder_pkg holds:
  - enum state_e {IDLE, DRAIN}
  - function lsb_index(vec) returning the index plus a found flag
- Natural sub-module: lsb_priority_encoder.
  - Combinational, parameter WIDTH.
  - Ports: in (WIDTH), idx (IDX_W), found (1).
  - Instantiated twice: once on vec_i, once on pending.
- The top level holds the FSM, the pending register and the output registers.

Test Plan:
1. Reset check: hold rst_ni low, then release. Required: vec_ready_o=1, idx_valid_o=0, idx_o=0, last_o=0 after reset.
2. Basic drain: WIDTH=8, vec_i=8'b1010_0100 accepted, idx_ready_i=1 throughout. Required: beats 2, 5, 7 on consecutive cycles; last_o=1 only on index 7; vec_ready_o=1 on the cycle after the final beat.
3. Backpressure: vec_i=8'h81, idx_ready_i low for 3 cycles then high. Required: idx_o=0 with last_o=0 held stable for 4 cycles; next beat idx_o=7 with last_o=1.
4. Single set bit: vec_i=8'h80. Required: exactly one beat, idx_o=7, last_o=1; return to IDLE.
5. Zero vector: vec_i=8'h00 accepted.
   - Without the macro: no beat; vec_ready_o stays 1.
   - With BITSCAN_ZERO_FLAG_EN: one beat with idx_o=0, last_o=1, zero_o=1.
6. Reset mid-drain: vec_i=8'hFF, assert rst_ni after 3 beats (idx 0, 1, 2). Required: idx_valid_o drops immediately without waiting for a clock; after release, vec_i=8'h02 yields a single beat idx_o=1, last_o=1.
